// File: rtl/cache_controller_if.sv
// Request handshake, datapath strobes and status bundle shared between the
// cache control FSM (slave side) and its requester/datapath (master side).
interface cache_controller_if #(
  parameter int ADDR_WIDTH  = 15,
  parameter int COUNT_WIDTH = 14
);
  logic                   reqValid;
  logic [ADDR_WIDTH-1:0]  reqAddress;
  logic                   reqReady;
  logic                   hit;
  logic                   checkHit;
  logic                   readCache;
  logic                   writeCache;
  logic                   readMem;
  logic                   hitCountEn;
  logic [ADDR_WIDTH-1:0]  address;
  logic                   respValid;
  logic                   respHit;
  logic [COUNT_WIDTH-1:0] accessCount;
  logic [COUNT_WIDTH-1:0] missCount;

  modport slave (
    input  reqValid, reqAddress, hit,
    output reqReady, checkHit, readCache, writeCache, readMem, hitCountEn,
           address, respValid, respHit, accessCount, missCount
  );

  modport master (
    output reqValid, reqAddress, hit,
    input  reqReady, checkHit, readCache, writeCache, readMem, hitCountEn,
           address, respValid, respHit, accessCount, missCount
  );
endinterface

// File: rtl/cache_controller.sv
// Control FSM for a direct-mapped cache datapath: tag check, miss fill with a
// fixed memory latency, read-out, one-cycle response and saturating counters.
module cache_controller #(
  parameter int ADDR_WIDTH  = 15,
  parameter int MEM_LATENCY = 4,
  parameter int COUNT_WIDTH = 14
) (
  input  logic               clk,
  input  logic               rstN,
  cache_controller_if.slave  bus
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(0);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    MEM_WAIT = 3'd2,
    FILL     = 3'd3,
    READ     = 3'd4,
    RESP     = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic                   flag_q, flag_d;
  logic                   ready_q;
  logic [COUNT_WIDTH-1:0] access_q, access_d;
  logic [COUNT_WIDTH-1:0] miss_q, miss_d;

  logic check_s;
  logic read_cache_s;
  logic write_cache_s;
  logic read_mem_s;
  logic hit_count_en_s;
  logic resp_valid_s;
  logic resp_hit_s;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + COUNT_WIDTH'(1);
    end
  endfunction

  // State and datapath registers; ready is held low for the first cycle after reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      address_q <= {ADDR_WIDTH{1'b0}};
      lat_q     <= LAT_ZERO;
      flag_q    <= 1'b0;
      ready_q   <= 1'b0;
      access_q  <= {COUNT_WIDTH{1'b0}};
      miss_q    <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      lat_q     <= lat_d;
      flag_q    <= flag_d;
      ready_q   <= (state_d == IDLE);
      access_q  <= access_d;
      miss_q    <= miss_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    lat_d     = lat_q;
    flag_d    = flag_q;
    access_d  = access_q;
    miss_d    = miss_q;
    case (state_q)
      IDLE: begin
        if (bus.reqValid && ready_q) begin
          address_d = bus.reqAddress;
          state_d   = CHECK;
        end else begin
          state_d   = IDLE;
        end
      end
      CHECK: begin
        if (bus.hit) begin
          flag_d  = 1'b1;
          state_d = READ;
        end else begin
          flag_d  = 1'b0;
          miss_d  = sat_inc(miss_q);
          lat_d   = LAT_INIT;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (lat_q == LAT_ZERO) begin
          state_d = FILL;
        end else begin
          lat_d   = lat_q - LAT_ONE;
        end
      end
      FILL: begin
        state_d = READ;
      end
      READ: begin
        state_d = RESP;
      end
      RESP: begin
        access_d = sat_inc(access_q);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe decode straight from the state register
  always_comb begin
    check_s        = 1'b0;
    read_cache_s   = 1'b0;
    write_cache_s  = 1'b0;
    read_mem_s     = 1'b0;
    hit_count_en_s = 1'b0;
    resp_valid_s   = 1'b0;
    resp_hit_s     = 1'b0;
    case (state_q)
      IDLE: begin
        check_s = 1'b0;
      end
      CHECK: begin
        check_s        = 1'b1;
        hit_count_en_s = bus.hit;
      end
      MEM_WAIT: begin
        read_mem_s = 1'b1;
      end
      FILL: begin
        read_mem_s    = 1'b1;
        write_cache_s = 1'b1;
      end
      READ: begin
        read_cache_s = 1'b1;
      end
      RESP: begin
        resp_valid_s = 1'b1;
        resp_hit_s   = flag_q;
      end
      default: begin
        check_s = 1'b0;
      end
    endcase
  end

  assign bus.reqReady    = ready_q;
  assign bus.checkHit    = check_s;
  assign bus.readCache   = read_cache_s;
  assign bus.writeCache  = write_cache_s;
  assign bus.readMem     = read_mem_s;
  assign bus.hitCountEn  = hit_count_en_s;
  assign bus.address     = address_q;
  assign bus.respValid   = resp_valid_s;
  assign bus.respHit     = resp_hit_s;
  assign bus.accessCount = access_q;
  assign bus.missCount   = miss_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: per-cycle timeline model of each access, random traffic,
// mid-run resets and counter saturation on a narrow-counter instance.
module tb_cache_controller;

  localparam int AW   = 15;
  localparam int LAT  = 4;
  localparam int CW   = 14;
  localparam int CWS  = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << CWS) - 1;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  cache_controller_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW))  bus ();
  cache_controller_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CWS)) sbus ();

  cache_controller #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rstN(rstN), .bus(bus)
  );

  cache_controller #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .COUNT_WIDTH(CWS)) dut_sat (
    .clk(clk), .rstN(rstN), .bus(sbus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_acc = 0;
  int m_miss = 0;

  // Expected {reqReady,checkHit,readCache,writeCache,readMem,hitCountEn,respValid,respHit}
  // for cycle k after acceptance (k=0 is the accepting IDLE cycle).
  function automatic logic [7:0] exp_vec(input bit h, input int k);
    bit rdy, chk, rc, wc, rm, hce, rv, rh;
    {rdy, chk, rc, wc, rm, hce, rv, rh} = 8'h00;
    if (k == 0) rdy = 1'b1;
    else if (k == 1) begin chk = 1'b1; hce = h; end
    else if (h) begin
      if (k == 2) rc = 1'b1;
      else if (k == 3) begin rv = 1'b1; rh = 1'b1; end
    end else begin
      if (k <= LAT + 1) rm = 1'b1;
      else if (k == LAT + 2) begin rm = 1'b1; wc = 1'b1; end
      else if (k == LAT + 3) rc = 1'b1;
      else if (k == LAT + 4) rv = 1'b1;
    end
    return {rdy, chk, rc, wc, rm, hce, rv, rh};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.reqReady, bus.checkHit, bus.readCache, bus.writeCache,
            bus.readMem, bus.hitCountEn, bus.respValid, bus.respHit};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic do_req(input logic [AW-1:0] addr, input bit h);
    logic [7:0] ev, ov;
    int n;
    n = h ? 3 : LAT + 4;
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqAddress = addr; bus.hit = 1'($urandom_range(0, 1));
    #1;
    n_cmp++;
    if (bus.reqReady !== 1'b1) begin
      n_err++; $display("FAIL idle_ready got %b want 1", bus.reqReady);
    end
    n_cmp++;
    if (bus.accessCount !== CW'(m_acc) || bus.missCount !== CW'(m_miss)) begin
      n_err++; $display("FAIL idle_counts got acc=%0d miss=%0d want acc=%0d miss=%0d",
                        bus.accessCount, bus.missCount, m_acc, m_miss);
    end
    if (!h) m_miss = sat(m_miss, CMAX);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.hit        = (k == 1) ? h : 1'($urandom_range(0, 1));
      bus.reqValid   = 1'($urandom_range(0, 1));
      bus.reqAddress = AW'($urandom);
      #1;
      ev = exp_vec(h, k);
      ov = obs_vec();
      n_cmp++;
      if (ov !== ev) begin
        n_err++; $display("FAIL strobes k=%0d hit=%0b got %b want %b", k, h, ov, ev);
      end
      n_cmp++;
      if (bus.address !== addr) begin
        n_err++; $display("FAIL address k=%0d got %h want %h", k, bus.address, addr);
      end
      if (k == n) begin
        n_cmp++;
        if (bus.missCount !== CW'(m_miss) || bus.accessCount !== CW'(m_acc)) begin
          n_err++; $display("FAIL resp_counts got acc=%0d miss=%0d want acc=%0d miss=%0d",
                            bus.accessCount, bus.missCount, m_acc, m_miss);
        end
      end
    end
    m_acc = sat(m_acc, CMAX);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.reqValid = 1'b0; bus.hit = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0) begin
        n_err++; $display("FAIL idle got ready=%b resp=%b want ready=1 resp=0", bus.reqReady, bus.respValid);
      end
      n_cmp++;
      if (bus.accessCount !== CW'(m_acc) || bus.missCount !== CW'(m_miss)) begin
        n_err++; $display("FAIL idle_counts got acc=%0d miss=%0d want acc=%0d miss=%0d",
                          bus.accessCount, bus.missCount, m_acc, m_miss);
      end
    end
  endtask

  task automatic check_reset_state(input string name);
    n_cmp++;
    if (obs_vec() !== 8'h00) begin
      n_err++; $display("FAIL %s_strobes got %b want 00000000", name, obs_vec());
    end
    n_cmp++;
    if (bus.address !== AW'(0) || bus.accessCount !== CW'(0) || bus.missCount !== CW'(0)) begin
      n_err++; $display("FAIL %s_regs got addr=%h acc=%0d miss=%0d want 0 0 0",
                        name, bus.address, bus.accessCount, bus.missCount);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    m_acc = 0; m_miss = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.reqReady !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset got %b want 1", bus.reqReady);
    end
  endtask

  task automatic test_reset(input string name);
    @(negedge clk);
    bus.reqValid = 1'b0;
    rstN = 1'b0;
    #1;
    check_reset_state(name);
    release_reset();
  endtask

  task automatic test_directed();
    do_req(15'h0404, 1'b0);
    do_req(15'h0405, 1'b1);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_req(AW'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqAddress = 15'h1234; bus.hit = 1'b1;
    @(negedge clk);
    bus.reqValid = 1'b0; bus.hit = 1'b0;
    @(negedge clk);
    bus.hit = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.readMem !== 1'b1) begin
      n_err++; $display("FAIL mid_miss_readmem got %b want 1", bus.readMem);
    end
    rstN = 1'b0;
    #1;
    check_reset_state("mid_miss");
    release_reset();
    idle(LAT + 4);
    do_req(15'h0404, 1'b0);
    do_req(15'h7fff, 1'b1);
    idle(1);
  endtask

  task automatic test_saturation();
    int resp_n;
    int p;
    bus.reqValid = 1'b0;
    resp_n = 0;
    for (int c = 0; c < 17 * 4; c++) begin
      @(negedge clk);
      sbus.reqValid = 1'b1; sbus.hit = 1'b1; sbus.reqAddress = AW'($urandom);
      #1;
      n_cmp++;
      if (sbus.respValid !== ((c % 4) == 3)) begin
        n_err++; $display("FAIL sat_hit_resp c=%0d got %b want %b", c, sbus.respValid, (c % 4) == 3);
      end
      if ((c % 4) == 3) begin
        n_cmp++;
        if (sbus.accessCount !== CWS'((resp_n > SMAX) ? SMAX : resp_n)) begin
          n_err++; $display("FAIL sat_acc_run got %0d want %0d", sbus.accessCount, (resp_n > SMAX) ? SMAX : resp_n);
        end
        resp_n++;
      end
    end
    @(negedge clk);
    sbus.reqValid = 1'b0;
    #1;
    n_cmp++;
    if (sbus.accessCount !== 4'd15 || sbus.missCount !== 4'd0) begin
      n_err++; $display("FAIL sat_acc got acc=%0d miss=%0d want acc=15 miss=0", sbus.accessCount, sbus.missCount);
    end
    p = LAT + 5;
    resp_n = 0;
    for (int c = 0; c < 17 * p; c++) begin
      @(negedge clk);
      sbus.reqValid = 1'b1; sbus.hit = 1'b0; sbus.reqAddress = AW'($urandom);
      #1;
      n_cmp++;
      if (sbus.respValid !== ((c % p) == p - 1)) begin
        n_err++; $display("FAIL sat_miss_resp c=%0d got %b want %b", c, sbus.respValid, (c % p) == p - 1);
      end
      if ((c % p) == p - 1) begin
        resp_n++;
        n_cmp++;
        if (sbus.missCount !== CWS'((resp_n > SMAX) ? SMAX : resp_n)) begin
          n_err++; $display("FAIL sat_miss_run got %0d want %0d", sbus.missCount, (resp_n > SMAX) ? SMAX : resp_n);
        end
      end
    end
    @(negedge clk);
    sbus.reqValid = 1'b0;
    #1;
    n_cmp++;
    if (sbus.missCount !== 4'd15 || sbus.accessCount !== 4'd15) begin
      n_err++; $display("FAIL sat_miss got acc=%0d miss=%0d want acc=15 miss=15", sbus.accessCount, sbus.missCount);
    end
  endtask

  initial begin
    bus.reqValid = 1'b0; bus.reqAddress = AW'(0); bus.hit = 1'b0;
    sbus.reqValid = 1'b0; sbus.reqAddress = AW'(0); sbus.hit = 1'b0;
    test_reset("reset");
    test_directed();
    test_random();
    test_reset("reset_mid_run");
    test_reset_mid_miss();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Control FSM that drives the direct-mapped cache datapath.
- Accepts one 15-bit read request at a time over a valid/ready handshake.
- Sequences the datapath strobes checkHit, readCache, writeCache, readMem and hitCountEn from the datapath's hit flag.
- On a miss, waits a fixed memory latency, fills the cache block, then reads.
- Reports completion with a one-cycle response pulse and keeps access and miss counts.

Parameters:
- ADDR_WIDTH, 15, request/datapath address width.
- MEM_LATENCY, 4, cycles readMem is held before the four block words are valid at the cache. Legal values are 1 or more.
- COUNT_WIDTH, 14, width of accessCount and missCount.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- reqValid  in  1  request present.
- reqAddress  in  ADDR_WIDTH  requested word address.
- reqReady  out  1  controller can accept a request.
- hit  in  1  datapath hit flag. Combinational, valid in the same cycle checkHit is high.
- checkHit  out  1  datapath tag-compare strobe.
- readCache  out  1  datapath read strobe (drives dataOut).
- writeCache  out  1  datapath block-fill strobe.
- readMem  out  1  memory block-read enable.
- hitCountEn  out  1  datapath hit counter increment.
- address  out  ADDR_WIDTH  registered address driven to the datapath.
- respValid  out  1  one-cycle completion pulse; datapath dataOut is valid.
- respHit  out  1  qualifies respValid: 1 means the access hit.
- accessCount  out  COUNT_WIDTH  completed accesses.
- missCount  out  COUNT_WIDTH  misses.

Behaviour:
- Reset (rstN low, async):
  - state goes to IDLE.
  - All strobes, respValid and respHit go to 0.
  - address, accessCount and missCount go to 0.
  - A reset mid-operation aborts the access: no response and no counter update.
- Strobe decoding is from the state register, not registered separately.
- IDLE:
  - reqReady=1.
  - On reqValid&&reqReady, latch reqAddress into address and go to CHECK.
  - reqReady is 0 in every other state. No request is queued.
- CHECK (1 cycle): checkHit=1, hit sampled.
  - If hit=1: hitCountEn=1 for this cycle, latch respHit flag=1, go to READ.
  - If hit=0: missCount increments, flag=0, load latency counter with MEM_LATENCY-1, go to MEM_WAIT.
- MEM_WAIT: readMem=1 every cycle. The counter decrements; when it is 0, go to FILL. Duration is exactly MEM_LATENCY cycles.
- FILL (1 cycle): readMem=1 and writeCache=1, then go to READ.
- READ (1 cycle): readCache=1, then go to RESP.
- RESP (1 cycle):
  - respValid=1 and respHit=flag.
  - accessCount increments, then go to IDLE.
  - There is no response backpressure.
- Strobe exclusivity: at most one of checkHit/readCache/writeCache is high in any cycle. readMem is high only in MEM_WAIT and FILL. hitCountEn is high only in CHECK with hit=1.
- address is held stable from acceptance through RESP.
- Latency, counted from the acceptance edge:
  - Hit: respValid in the 3rd cycle after acceptance; each hit request occupies 4 cycles including IDLE.
  - Miss: respValid in cycle 3+MEM_LATENCY+1 after acceptance.
- Counters saturate at all-ones and do not wrap.
- hit is ignored outside CHECK.
- reqValid is ignored outside IDLE.
- reqAddress changes while busy have no effect.

Test Plan:
1. Reset: assert rstN=0 mid-run → all strobes 0, reqReady=0 during reset and 1 after release, address=0, accessCount=0, missCount=0.
2. Miss, MEM_LATENCY=4: request 0x0404 with hit=0.
   - checkHit one cycle; readMem high 5 consecutive cycles; writeCache high in the 5th only; readCache the cycle after.
   - respValid 8 cycles after acceptance, respHit=0, missCount=1, accessCount=1, no hitCountEn.
3. Hit: request 0x0405 with hit=1 → hitCountEn one pulse in CHECK, readMem never high, respValid 3 cycles after acceptance, respHit=1, accessCount=2, missCount=1.
4. Busy handling: hold reqValid=1 with changing reqAddress during a miss → reqReady=0 until IDLE; next acceptance occurs the cycle after RESP; address stays 0x0404 throughout the miss.
5. Reset mid-miss: drop rstN in the 2nd MEM_WAIT cycle → readMem drops immediately, no respValid, counters 0, and the next request is handled normally.
6. Saturation with COUNT_WIDTH=4:
   - 17 back-to-back hits → accessCount=15, not 0.
   - Throughput is exactly one response per 4 cycles.
   - 17 misses → missCount=15.
